// File: rtl/dj8_bus_io.sv
// DJ8 downstream bus stage: address decode, external memory strobes,
// and an on-chip I/O page with GPIO, 8N1 UART transmitter and timer.
module dj8_bus_io #(
  parameter logic [7:0] IO_PAGE      = 8'hFF,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         TIMER_DIV    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we_n,
  input  logic        cpu_wcycle,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic        ext_ce_n,
  output logic        ext_we_n,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  logic          io_sel;
  logic          io_wr;
  logic [7:0]    off;
  logic          wr_gpio;
  logic          wr_tx;
  logic          wr_stat;
  logic          wr_timer;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  tx_state_t     state;
  logic          tx_busy;
  logic          overrun;
  logic [7:0]    tx_data;
  logic [7:0]    shift;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    timer;
  logic [PW-1:0] pre;
  logic [7:0]    io_rdata;

  assign off      = cpu_addr[7:0];
  assign io_sel   = (cpu_addr[15:8] == IO_PAGE);
  assign io_wr    = io_sel & ~cpu_we_n & cpu_wcycle;
  assign wr_gpio  = io_wr & (off == 8'h00);
  assign wr_tx    = io_wr & (off == 8'h02);
  assign wr_stat  = io_wr & (off == 8'h03);
  assign wr_timer = io_wr & (off == 8'h04);

  // The I/O page deselects external memory and masks its write strobe.
  assign ext_addr  = cpu_addr;
  assign ext_wdata = cpu_wdata;
  assign ext_ce_n  = io_sel;
  assign ext_we_n  = cpu_we_n | ext_ce_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= 8'h00;
      sync1    <= 8'h00;
      sync2    <= 8'h00;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr_gpio) gpio_out <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_data <= 8'h00;
      shift   <= 8'h00;
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_tx) begin
            tx_data <= cpu_wdata;
            shift   <= cpu_wdata;
            state   <= START;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
            cnt     <= '0;
          end
        end
        START: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
            uart_tx <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            state   <= IDLE;
            tx_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // A dropped byte sets overrun even if the same write tries to clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else overrun <= (wr_tx & tx_busy) | (overrun & ~wr_stat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 8'h00;
      pre   <= '0;
    end else if (wr_timer) begin
      timer <= cpu_wdata;
      pre   <= '0;
    end else if (pre == PRE_LAST) begin
      timer <= timer + 8'd1;
      pre   <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    unique case (off)
      8'h00:   io_rdata = gpio_out;
      8'h01:   io_rdata = sync2;
      8'h02:   io_rdata = tx_data;
      8'h03:   io_rdata = {6'b0, overrun, tx_busy};
      8'h04:   io_rdata = timer;
      default: io_rdata = 8'h00;
    endcase
  end

  assign cpu_rdata = io_sel ? io_rdata : ext_rdata;

endmodule
